// File: rtl/eeg_sample_writer.sv
// eeg_sample_writer: streams ADC samples into intermediate-result memory as double-width Q(10,20) words
module eeg_sample_writer #(
  parameter int NUM_SAMPLES = 3840,
  parameter int BASE_ADDR   = 0,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              adc_valid_i,
  input  logic [15:0]       adc_data_i,
  output logic              adc_ready_o,
  output logic              mem_wr_en_o,
  input  logic              mem_gnt_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [29:0]       mem_data_o,
  output logic              mem_width_o,
  output logic [2:0]        mem_format_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [11:0]       count_o
);
  localparam logic [1:0] IDLE = 2'd0, ACCEPT = 2'd1, WRITE = 2'd2, DONE = 2'd3;
  localparam logic [11:0] LAST = 12'(NUM_SAMPLES - 1);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  logic [1:0] state_q, state_d;
  logic [11:0] count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [29:0] data_q, data_d;
  logic go, gnt, last;
  assign go   = state_q == IDLE && start_i;
  assign gnt  = state_q == WRITE && mem_gnt_i;
  assign last = count_q == LAST;
  always_comb begin
    state_d = state_q == IDLE   ? (start_i ? ACCEPT : IDLE) :
              state_q == ACCEPT ? (adc_valid_i ? WRITE : ACCEPT) :
              state_q == WRITE  ? (mem_gnt_i ? (last ? DONE : ACCEPT) : WRITE) : IDLE;
    count_d = go ? '0 : gnt ? count_q + 12'd1 : count_q;
    // address stops at the final word so it never leaves the load's window
    addr_d  = go ? BASE : (gnt && !last) ? addr_q + ADDR_W'(1) : addr_q;
    data_d  = (state_q == ACCEPT && adc_valid_i) ? {1'b0, adc_data_i, 13'b0} : data_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= BASE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end
  assign adc_ready_o  = state_q == ACCEPT;
  assign mem_wr_en_o  = state_q == WRITE;
  assign busy_o       = state_q != IDLE;
  assign done_o       = state_q == DONE;
  assign mem_addr_o   = addr_q;
  assign mem_data_o   = data_q;
  assign count_o      = count_q;
  assign mem_width_o  = 1'b1;
  assign mem_format_o = 3'd4;
endmodule

// File: tb/tb_eeg_sample_writer.sv
// tb_eeg_sample_writer: transaction-level model of the sample stream checked against the DUT every cycle
module tb_eeg_sample_writer;
  localparam int N = 3840;
  logic clk = 0, rst = 1, start_i = 0, adc_valid_i = 0, mem_gnt_i = 1;
  logic [15:0] adc_data_i = 0;
  logic adc_ready_o, mem_wr_en_o, mem_width_o, busy_o, done_o;
  logic [15:0] mem_addr_o;
  logic [29:0] mem_data_o;
  logic [2:0] mem_format_o;
  logic [11:0] count_o;
  int n_chk = 0, n_fail = 0;
  int exp_idx = 0, src_idx = 0, done_n = 0, cyc = 0, stall_n = 0, done_cyc = 0, start_cyc = 0;
  logic m_busy = 0, was_busy = 0, acc = 0, sparse = 0, stall_en = 0;

  always #5 clk = ~clk;

  eeg_sample_writer dut (
    .clk(clk), .rst(rst), .start_i(start_i), .adc_valid_i(adc_valid_i), .adc_data_i(adc_data_i),
    .adc_ready_o(adc_ready_o), .mem_wr_en_o(mem_wr_en_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_width_o(mem_width_o),
    .mem_format_o(mem_format_o), .busy_o(busy_o), .done_o(done_o), .count_o(count_o)
  );

  // sample k of every load; k=0 and k=1 hit the 0x0000 and 0xFFFF boundaries
  function automatic logic [15:0] sample(input int k);
    return k == 1 ? 16'hFFFF : 16'(k * 40503);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    chk("width", 32'(mem_width_o), 1);
    chk("format", 32'(mem_format_o), 4);
    if (rst) begin
      chk("rst_ctrl", 32'({adc_ready_o, mem_wr_en_o, busy_o, done_o}), 0);
      chk("rst_count", 32'(count_o), 0);
      chk("rst_addr", 32'(mem_addr_o), 0);
      chk("rst_data", 32'(mem_data_o), 0);
      m_busy = 0; exp_idx = 0; acc = 0;
    end else begin
      chk("busy", 32'(busy_o), 32'(m_busy));
      chk("done", 32'(done_o), 32'(m_busy && exp_idx == N));
      chk("count", 32'(count_o), exp_idx);
      chk("rdy_wr_excl", 32'(adc_ready_o & mem_wr_en_o), 0);
      if (!m_busy || exp_idx == N) chk("quiet", 32'({adc_ready_o, mem_wr_en_o}), 0);
      if (mem_wr_en_o) begin
        chk("addr", 32'(mem_addr_o), exp_idx);
        chk("data", 32'(mem_data_o), 32'({1'b0, sample(exp_idx), 13'b0}));
        if (exp_idx == 0) chk("lit_zero", 32'(mem_data_o), 32'h0);
        if (exp_idx == 1) chk("lit_ffff", 32'(mem_data_o), 32'h1FFFE000);
        if (!mem_gnt_i) stall_n++;
      end
      acc = adc_valid_i & adc_ready_o;
      if (done_o) begin done_n++; done_cyc = cyc; end
      was_busy = m_busy;
      if (m_busy && exp_idx == N) m_busy = 0;
      else if (mem_wr_en_o && mem_gnt_i) exp_idx++;
      if (start_i && !was_busy) begin m_busy = 1; exp_idx = 0; start_cyc = cyc; end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    if (acc) src_idx++;
    start_i = 0;
    adc_data_i = sample(src_idx);
    if (!sparse) adc_valid_i = 1;
    else if (acc || !adc_valid_i) adc_valid_i = (cyc % 7 == 0);
    mem_gnt_i = !(stall_en && exp_idx == 10 && stall_n < 5);
  endtask

  task automatic run_load(input logic sp, input logic st, input logic s100, input logic r500, input int budget);
    logic pulsed, fin;
    pulsed = 0; fin = 0;
    sparse = sp; stall_en = st; src_idx = 0; done_n = 0; stall_n = 0;
    tick();
    start_i = 1;
    for (int i = 0; i < budget && !fin; i++) begin
      tick();
      if (s100 && !pulsed && exp_idx == 100) begin start_i = 1; pulsed = 1; end
      if (r500 && exp_idx == 500) begin
        rst = 1; #1;
        chk("async_rst_ctrl", 32'({adc_ready_o, mem_wr_en_o, busy_o, done_o}), 0);
        chk("async_rst_count", 32'(count_o), 0);
        chk("async_rst_addr", 32'(mem_addr_o), 0);
        chk("async_rst_data", 32'(mem_data_o), 0);
        @(posedge clk); #1;
        rst = 0; fin = 1;
      end
      if (done_n > 0 && !m_busy) fin = 1;
    end
    if (!fin) chk("timeout", 0, 1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    run_load(0, 0, 0, 0, 9000);
    chk("full_done_once", done_n, 1);
    chk("full_count", 32'(count_o), 3840);
    chk("full_latency", 32'(done_cyc - start_cyc >= 7680 && done_cyc - start_cyc <= 7682), 1);
    repeat (4) tick();
    chk("hold_count", 32'(count_o), 3840);
    chk("hold_idle", 32'(busy_o), 0);
    run_load(0, 1, 1, 0, 9000);
    chk("stall_cycles", stall_n, 5);
    chk("stall_done_once", done_n, 1);
    chk("stall_count", 32'(count_o), 3840);
    run_load(1, 0, 0, 0, 30000);
    chk("sparse_done_once", done_n, 1);
    chk("sparse_count", 32'(count_o), 3840);
    run_load(0, 0, 0, 1, 2000);
    chk("rst_no_done", done_n, 0);
    chk("rst_count_after", 32'(count_o), 0);
    run_load(0, 0, 0, 0, 9000);
    chk("reload_done_once", done_n, 1);
    chk("reload_count", 32'(count_o), 3840);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
